// File: rtl/zmod_dac_sequencer_pkg.sv
// Shared types for the ZMOD DAC sequencer:
// FSM state encoding and timer sizing helper.
package zmod_dac_sequencer_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE,
    ST_WARMUP,
    ST_RELAY_ON,
    ST_RUN,
    ST_MUTE,
    ST_RELAY_OFF
  } state_t;

  function automatic int timer_w(
    input int a,
    input int b
  );
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/zmod_dac_slot_arbiter.sv
// Sample slot divider, fixed-priority grant
// between two sources, output hold and underflow.
module zmod_dac_slot_arbiter #(
  parameter int DATA_W     = 14,
  parameter int SAMPLE_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              clr,
  input  logic [DATA_W-1:0] data_i_0,
  input  logic [DATA_W-1:0] data_q_0,
  input  logic              valid_0,
  output logic              ready_0,
  input  logic [DATA_W-1:0] data_i_1,
  input  logic [DATA_W-1:0] data_q_1,
  input  logic              valid_1,
  output logic              ready_1,
  output logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] data_q,
  output logic              underflow,
  output logic [15:0]       underflow_cnt
);

  localparam int DIV_W =
    (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST =
    DIV_W'(SAMPLE_DIV - 1);

  logic [DIV_W-1:0] div;
  logic             strobe;
  logic             slot;
  logic             xfer_0;
  logic             xfer_1;
  logic             empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div <= '0;
    end else if (div == DIV_LAST) begin
      div <= '0;
    end else begin
      div <= div + 1'b1;
    end
  end

  assign strobe  = (div == '0);
  assign slot    = run & strobe;
  assign ready_0 = slot;
  assign ready_1 = slot & ~valid_0;
  assign xfer_0  = valid_0 & ready_0;
  assign xfer_1  = valid_1 & ready_1;
  assign empty   = slot & ~valid_0 & ~valid_1;

  // Mute clear overrides any grant in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_i <= '0;
      data_q <= '0;
    end else if (clr) begin
      data_i <= '0;
      data_q <= '0;
    end else if (xfer_0) begin
      data_i <= data_i_0;
      data_q <= data_q_0;
    end else if (xfer_1) begin
      data_i <= data_i_1;
      data_q <= data_q_1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow     <= 1'b0;
      underflow_cnt <= '0;
    end else begin
      underflow <= empty;
      if (empty && underflow_cnt != 16'hFFFF) begin
        underflow_cnt <= underflow_cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/zmod_dac_sequencer.sv
// ZMOD DAC run/relay sequencer with
// relay-safe power-up/down and stream pacing.
module zmod_dac_sequencer
  import zmod_dac_sequencer_pkg::*;
#(
  parameter int DATA_W        = 14,
  parameter int SAMPLE_DIV    = 1,
  parameter int SETTLE_CYCLES = 1024,
  parameter int RELAY_CYCLES  = 100000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_enable,
  input  logic [DATA_W-1:0] is_data_i_0,
  input  logic [DATA_W-1:0] is_data_q_0,
  input  logic              i_valid_0,
  output logic              o_ready_0,
  input  logic [DATA_W-1:0] is_data_i_1,
  input  logic [DATA_W-1:0] is_data_q_1,
  input  logic              i_valid_1,
  output logic              o_ready_1,
  output logic [DATA_W-1:0] os_data_i,
  output logic [DATA_W-1:0] os_data_q,
  output logic              o_run,
  output logic              o_relay,
  output logic              o_active,
  output logic              o_underflow,
  output logic [15:0]       or16_underflow_cnt
);

  localparam int TMR_W =
    timer_w(SETTLE_CYCLES, RELAY_CYCLES);
  localparam logic [TMR_W-1:0] SETTLE_LD =
    TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] RELAY_LD =
    TMR_W'(RELAY_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic             tmr_done;

  assign tmr_done = (tmr == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= ST_IDLE;
      tmr   <= '0;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Timer loads on state entry; leave on terminal count
  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    if (!tmr_done) tmr_nxt = tmr - 1'b1;
    case (state)
      ST_IDLE: begin
        if (i_enable) begin
          state_nxt = ST_WARMUP;
          tmr_nxt   = SETTLE_LD;
        end
      end
      ST_WARMUP: begin
        if (!i_enable) begin
          state_nxt = ST_IDLE;
        end else if (tmr_done) begin
          state_nxt = ST_RELAY_ON;
          tmr_nxt   = RELAY_LD;
        end
      end
      ST_RELAY_ON: begin
        if (!i_enable) begin
          state_nxt = ST_MUTE;
          tmr_nxt   = SETTLE_LD;
        end else if (tmr_done) begin
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!i_enable) begin
          state_nxt = ST_MUTE;
          tmr_nxt   = SETTLE_LD;
        end
      end
      ST_MUTE: begin
        if (tmr_done) begin
          state_nxt = ST_RELAY_OFF;
          tmr_nxt   = RELAY_LD;
        end
      end
      ST_RELAY_OFF: begin
        if (tmr_done) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      o_run    <= 1'b0;
      o_relay  <= 1'b0;
      o_active <= 1'b0;
    end else begin
      o_run    <= (state_nxt != ST_IDLE);
      o_relay  <= (state_nxt == ST_RELAY_ON) ||
                  (state_nxt == ST_RUN) ||
                  (state_nxt == ST_MUTE);
      o_active <= (state_nxt == ST_RUN);
    end
  end

  zmod_dac_slot_arbiter #(
    .DATA_W     (DATA_W),
    .SAMPLE_DIV (SAMPLE_DIV)
  ) u_arb (
    .clk           (clk),
    .rst_n         (rstn),
    .run           (state == ST_RUN),
    .clr           (state_nxt != ST_RUN),
    .data_i_0      (is_data_i_0),
    .data_q_0      (is_data_q_0),
    .valid_0       (i_valid_0),
    .ready_0       (o_ready_0),
    .data_i_1      (is_data_i_1),
    .data_q_1      (is_data_q_1),
    .valid_1       (i_valid_1),
    .ready_1       (o_ready_1),
    .data_i        (os_data_i),
    .data_q        (os_data_q),
    .underflow     (o_underflow),
    .underflow_cnt (or16_underflow_cnt)
  );

endmodule

// File: doc/zmod_dac_sequencer.md
# zmod_dac_sequencer

Controller between the signal sources and the ZMOD DAC driver. Owns the DAC run enable, output relay and sample pacing; arbitrates between a primary stream (filter/signal path) and a secondary stream (test tone) at each sample slot. It also runs relay-safe power-up and power-down sequences so the analog output never sees a live, non-zero code while the relay switches.

## Interface
Parameters:
- DATA_W, 14, sample width (signed I/Q)
- SAMPLE_DIV, 1, clk cycles per sample slot (≥1)
- SETTLE_CYCLES, 1024, DAC settle time with zero code, before relay close and after mute
- RELAY_CYCLES, 100000, relay mechanical settle time

Ports:
- clk  in  1  single clock
- rstn  in  1  reset; asynchronous, active-low
- i_enable  in  1  level request for analog output on
- is_data_i_0 / is_data_q_0  in  DATA_W  primary source I/Q
- i_valid_0  in  1  primary sample valid
- o_ready_0  out  1  primary sample accepted
- is_data_i_1 / is_data_q_1  in  DATA_W  secondary source I/Q
- i_valid_1  in  1  secondary sample valid
- o_ready_1  out  1  secondary sample accepted
- os_data_i / os_data_q  out  DATA_W  registered samples to DAC driver
- o_run  out  1  DAC driver run enable
- o_relay  out  1  output relay close
- o_active  out  1  high only in RUN
- o_underflow  out  1  one-cycle pulse on empty slot
- or16_underflow_cnt  out  16  saturating underflow count

## Operation
- FSM states: IDLE, WARMUP, RELAY_ON, RUN, MUTE, RELAY_OFF.
- IDLE: o_run=0, o_relay=0, data=0. i_enable=1 → WARMUP.
- WARMUP: o_run=1, data=0; SETTLE_CYCLES then → RELAY_ON.
- RELAY_ON: o_relay=1, data=0; RELAY_CYCLES then → RUN.
- RUN: streaming (below). i_enable=0 → MUTE.
- MUTE: data forced 0, relay still closed; SETTLE_CYCLES then → RELAY_OFF.
- RELAY_OFF: o_relay=0, o_run=1, data=0; RELAY_CYCLES then → IDLE.
- i_enable=0 in WARMUP → IDLE directly (relay never closed); in RELAY_ON → MUTE (full shutdown).
- i_enable=1 during MUTE/RELAY_OFF is ignored; shutdown completes, IDLE re-evaluates i_enable.
- Slot strobe: divider counts 0..SAMPLE_DIV-1, strobe at 0; runs continuously out of reset; SAMPLE_DIV=1 → strobe every cycle.
- Arbitration (RUN, strobe only): fixed priority. o_ready_0 = RUN & strobe. o_ready_1 = RUN & strobe & !i_valid_0. Transfer = valid & ready. Both ready low outside RUN/strobe.
- Empty slot (RUN, strobe, neither valid): hold last output sample, pulse o_underflow, increment counter, saturating at 0xFFFF. Counter clears only on reset.
- Entering RUN: output holds zero until first transfer.
- Data passes unmodified (no scaling); width DATA_W both sides.

## Timing
- Reset: state IDLE, all outputs 0, divider 0, counters 0.
- Output latency: transfer in cycle N → os_data_* valid at N+1.
- State dwell exactly the parameter count of cycles (counter loads on entry, transition on terminal count).
- o_run/o_relay/o_active registered, change on the edge of state entry.
- Mute applies in the first cycle of MUTE: os_data_* = 0 at that edge.
- Source presenting valid on a non-strobe cycle must hold it until ready; no drop.

## Structure
- Shared package: state encoding enum, STATE_W, counter width from $clog2(max(SETTLE_CYCLES, RELAY_CYCLES)+1).
- One sub-module: zmod_dac_slot_arbiter (strobe divider + priority grant + hold/underflow); FSM and timers in top.

## Test plan
- Power-up: SETTLE=4, RELAY=8, i_enable↑ at t0 → o_run at t0+1, o_relay at t0+5, o_active at t0+13; data 0 throughout.
- Priority: both valid, DIV=1, src0=0x0123, src1=0x1FFF → only o_ready_0, output 0x0123 one cycle later; src1 held until src0 drops.
- Pacing: DIV=4, src0 always valid → one transfer every 4 cycles, ready high only on strobe.
- Underflow: no valids for 3 slots after 0x0ABC → output holds 0x0ABC, 3 pulses, count=3; force 70000 slots → count 0xFFFF.
- Shutdown: i_enable↓ in RUN with data 0x1000 → data 0 next edge, relay opens after 4, o_run low after 8 more; re-enable mid-shutdown delays restart until IDLE.
- Async reset mid-RUN → all outputs 0 immediately, state IDLE, no ready pulses.
